// File: rtl/uart_program_loader.sv
// UART boot loader: receives a length-prefixed program image over 8N1 serial,
// writes little-endian 32-bit words into instruction memory, then releases the core.
module uart_program_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_WIDTH   = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  uart_rx,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_rst,
    output logic                  load_done,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int HALF = CLKS_PER_BIT / 2;

    localparam logic [CW-1:0]         FULL_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]         HALF_M1  = CW'(HALF - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
    localparam logic [32:0]           CAP      = 33'(1) << ADDR_WIDTH;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    typedef enum logic [2:0] {
        LD_HDR_LO,
        LD_HDR_HI,
        LD_WORD,
        LD_LAST,
        LD_DONE
    } ld_state_e;

    // ---------------------------------------------------------------
    // Input synchroniser plus one extra flop for falling-edge detect
    // ---------------------------------------------------------------
    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Two-flop synchroniser for the asynchronous line, idle high
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= uart_rx;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    // ---------------------------------------------------------------
    // RX FSM
    // ---------------------------------------------------------------
    rx_state_e     rx_state_q, rx_state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          byte_valid_q, byte_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          stop_bad;

    // RX state register and bit-timing counters
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q   <= RX_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // RX next state: mid-bit sampling, glitch rejection, stop-bit check
    always_comb begin
        rx_state_d   = rx_state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = frame_err_q;
        stop_bad     = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                if (prev_q && !sync_q) begin
                    rx_state_d = RX_START;
                    cnt_d      = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d      = '0;
                    bit_d      = '0;
                    rx_state_d = sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d      = '0;
                    rx_state_d = RX_IDLE;
                    if (sync_q) begin
                        byte_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        stop_bad    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Loader FSM
    // ---------------------------------------------------------------
    ld_state_e             ld_state_q, ld_state_d;
    logic [15:0]           count_q, count_d;
    logic [15:0]           words_q, words_d;
    logic [1:0]            idx_q, idx_d;
    logic [23:0]           word_q, word_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;

    // Loader state, header, word assembly and registered write port
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_state_q <= LD_HDR_LO;
            count_q    <= '0;
            words_q    <= '0;
            idx_q      <= '0;
            word_q     <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            ld_state_q <= ld_state_d;
            count_q    <= count_d;
            words_q    <= words_d;
            idx_q      <= idx_d;
            word_q     <= word_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    // Loader next state: header, LE word packing, capacity-limited writes
    always_comb begin
        ld_state_d = ld_state_q;
        count_d    = count_q;
        words_d    = words_q;
        idx_d      = idx_q;
        word_d     = word_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if (we_q && addr_q != ADDR_MAX) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
        end
        if (stop_bad && ld_state_q != LD_DONE) begin
            ld_state_d = LD_HDR_LO;
            idx_d      = '0;
            words_d    = '0;
            addr_d     = '0;
        end else begin
            unique case (ld_state_q)
                LD_HDR_LO: begin
                    if (byte_valid_q) begin
                        count_d[7:0] = shift_q;
                        ld_state_d   = LD_HDR_HI;
                    end
                end
                LD_HDR_HI: begin
                    if (byte_valid_q) begin
                        count_d[15:8] = shift_q;
                        idx_d         = '0;
                        words_d       = '0;
                        if ({shift_q, count_q[7:0]} == 16'd0) begin
                            ld_state_d = LD_DONE;
                        end else begin
                            ld_state_d = LD_WORD;
                        end
                    end
                end
                LD_WORD: begin
                    if (byte_valid_q) begin
                        idx_d = idx_q + 2'd1;
                        unique case (idx_q)
                            2'd0: word_d[7:0]   = shift_q;
                            2'd1: word_d[15:8]  = shift_q;
                            2'd2: word_d[23:16] = shift_q;
                            default: begin
                                words_d = words_q + 16'd1;
                                if ({17'b0, words_q} < CAP) begin
                                    we_d    = 1'b1;
                                    wdata_d = {shift_q, word_q};
                                end
                                if (words_d == count_q) begin
                                    ld_state_d = LD_LAST;
                                end
                            end
                        endcase
                    end
                end
                LD_LAST: ld_state_d = LD_DONE;
                LD_DONE: ld_state_d = LD_DONE;
                default: ld_state_d = LD_HDR_LO;
            endcase
        end
    end

    // Status decode from registered state
    always_comb begin
        load_done = (ld_state_q == LD_DONE);
        cpu_rst   = !load_done;
        busy      = !load_done &&
                    ((rx_state_q != RX_IDLE) ||
                     (ld_state_q == LD_HDR_HI) ||
                     (ld_state_q == LD_WORD && idx_q != 2'd0));
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader: two DUTs share clk/rst, one with a
// four-word memory for the overflow case; a negedge monitor logs writes.
module tb_uart_program_loader;

    localparam int CPB  = 4;
    localparam int HALF = CPB / 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx  = 1'b1;
    logic sel = 1'b0;
    logic rx_a;
    logic rx_b;

    logic        we_a, cpurst_a, done_a, ferr_a, busy_a;
    logic [9:0]  addr_a;
    logic [31:0] wdata_a;
    logic        we_b, cpurst_b, done_b, ferr_b, busy_b;
    logic [1:0]  addr_b;
    logic [31:0] wdata_b;

    assign rx_a = sel ? 1'b1 : tx;
    assign rx_b = sel ? tx : 1'b1;

    uart_program_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(10)) dut_a (
        .clk(clk), .rst(rst), .uart_rx(rx_a),
        .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wdata_a),
        .cpu_rst(cpurst_a), .load_done(done_a), .frame_err(ferr_a), .busy(busy_a)
    );

    uart_program_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(2)) dut_b (
        .clk(clk), .rst(rst), .uart_rx(rx_b),
        .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wdata_b),
        .cpu_rst(cpurst_b), .load_done(done_b), .frame_err(ferr_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] wd_a [8];
    int          wa_a [8];
    int          wn_a, wcyc_a, dcyc_a;
    logic        dseen_a;
    logic [31:0] wd_b [8];
    int          wa_b [8];
    int          wn_b, dcyc_b;
    logic        dseen_b;

    always @(negedge clk) begin
        if (rst) begin
            wn_a <= 0; wn_b <= 0;
            dseen_a <= 1'b0; dseen_b <= 1'b0;
            dcyc_a <= -1; dcyc_b <= -1; wcyc_a <= -1;
        end else begin
            if (we_a) begin
                if (wn_a < 8) begin
                    wd_a[wn_a] <= wdata_a;
                    wa_a[wn_a] <= int'(addr_a);
                end
                wn_a   <= wn_a + 1;
                wcyc_a <= cyc;
            end
            if (done_a && !dseen_a) begin
                dseen_a <= 1'b1;
                dcyc_a  <= cyc;
            end
            if (we_b) begin
                if (wn_b < 8) begin
                    wd_b[wn_b] <= wdata_b;
                    wa_b[wn_b] <= int'(addr_b);
                end
                wn_b <= wn_b + 1;
            end
            if (done_b && !dseen_b) begin
                dseen_b <= 1'b1;
                dcyc_b  <= cyc;
            end
        end
    end

    int n_tot  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int st     = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stopb);
        @(posedge clk); #1 tx = 1'b0;
        st = cyc;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge clk);
            #1 tx = b[i];
        end
        repeat (CPB) @(posedge clk);
        #1 tx = stopb;
        repeat (CPB) @(posedge clk);
        #1 tx = 1'b1;
        repeat (8) @(posedge clk);
    endtask

    task automatic send_n(input logic [127:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            send_byte(d[8*(n-1-i) +: 8], 1'b1);
        end
    endtask

    task automatic pulse_rst();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    initial begin
        int w;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we",    {31'b0, we_a},     32'd0);
        chk("rst_addr",  {22'b0, addr_a},   32'd0);
        chk("rst_wdata", wdata_a,           32'd0);
        chk("rst_cpurst",{31'b0, cpurst_a}, 32'd1);
        chk("rst_done",  {31'b0, done_a},   32'd0);
        chk("rst_ferr",  {31'b0, ferr_a},   32'd0);
        chk("rst_busy",  {31'b0, busy_a},   32'd0);
        rst = 1'b0;

        // two-word load
        send_n(128'h02_00_13_05_00_00_93_05_10_00, 10);
        @(negedge clk);
        chk("t1_nwr",   wn_a,                2);
        chk("t1_a0",    wa_a[0],             0);
        chk("t1_d0",    wd_a[0],             32'h0000_0513);
        chk("t1_a1",    wa_a[1],             1);
        chk("t1_d1",    wd_a[1],             32'h0010_0593);
        chk("t1_wlat",  wcyc_a - st,         42);
        chk("t1_dlat",  dcyc_a - wcyc_a,     1);
        chk("t1_done",  {31'b0, done_a},     32'd1);
        chk("t1_cpurst",{31'b0, cpurst_a},   32'd0);
        chk("t1_busy",  {31'b0, busy_a},     32'd0);
        chk("t1_addr",  {22'b0, addr_a},     32'd2);

        // empty image
        pulse_rst();
        @(negedge clk);
        chk("t2_rdone", {31'b0, done_a},     32'd0);
        send_n(128'h00_00, 2);
        @(negedge clk);
        chk("t2_nwr",   wn_a,                0);
        chk("t2_dlat",  dcyc_a - st,         42);
        chk("t2_done",  {31'b0, done_a},     32'd1);
        chk("t2_cpurst",{31'b0, cpurst_a},   32'd0);

        // frame error then clean reload
        pulse_rst();
        send_n(128'h01_00_13_05, 4);
        send_byte(8'h00, 1'b0);
        @(negedge clk);
        chk("t3_ferr",  {31'b0, ferr_a},     32'd1);
        chk("t3_nwr0",  wn_a,                0);
        chk("t3_done0", {31'b0, done_a},     32'd0);
        send_n(128'h01_00_13_05_00_00, 6);
        @(negedge clk);
        chk("t3_nwr",   wn_a,                1);
        chk("t3_a0",    wa_a[0],             0);
        chk("t3_d0",    wd_a[0],             32'h0000_0513);
        chk("t3_done",  {31'b0, done_a},     32'd1);
        chk("t3_ferr2", {31'b0, ferr_a},     32'd1);

        // glitch rejection
        pulse_rst();
        @(posedge clk); #1 tx = 1'b0;
        @(posedge clk); #1 tx = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t4_busyhi", {31'b0, busy_a},    32'd1);
        w = 0;
        while (busy_a && w < HALF + 3) begin
            @(negedge clk);
            w++;
        end
        chk("t4_busylo", {31'b0, busy_a},    32'd0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("t4_nwr0",  wn_a,                0);
        chk("t4_ferr",  {31'b0, ferr_a},     32'd0);
        send_n(128'h01_00_11_22_33_44, 6);
        @(negedge clk);
        chk("t4_nwr",   wn_a,                1);
        chk("t4_d0",    wd_a[0],             32'h4433_2211);
        chk("t4_done",  {31'b0, done_a},     32'd1);

        // reset mid-load
        pulse_rst();
        send_n(128'h02_00_13_05_00_00_93, 7);
        @(negedge clk);
        chk("t5_nwr0",  wn_a,                1);
        chk("t5_addr1", {22'b0, addr_a},     32'd1);
        pulse_rst();
        @(negedge clk);
        chk("t5_cpurst",{31'b0, cpurst_a},   32'd1);
        chk("t5_addr",  {22'b0, addr_a},     32'd0);
        chk("t5_done0", {31'b0, done_a},     32'd0);
        chk("t5_busy",  {31'b0, busy_a},     32'd0);
        send_n(128'h01_00_AA_BB_CC_DD, 6);
        @(negedge clk);
        chk("t5_nwr",   wn_a,                1);
        chk("t5_a0",    wa_a[0],             0);
        chk("t5_d0",    wd_a[0],             32'hDDCC_BBAA);
        chk("t5_done",  {31'b0, done_a},     32'd1);

        // overflow on a four-word memory
        pulse_rst();
        sel = 1'b1;
        send_n(128'h05_00, 2);
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 4; j++) begin
                send_byte(8'(i * 16 + j), 1'b1);
            end
        end
        @(negedge clk);
        chk("t6_nwr",   wn_b,                4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t6_a%0d", i), wa_b[i], i);
            chk($sformatf("t6_d%0d", i), wd_b[i],
                32'h0302_0100 + 32'(i) * 32'h1010_1010);
        end
        chk("t6_done",  {31'b0, done_b},     32'd1);
        chk("t6_cpurst",{31'b0, cpurst_b},   32'd0);
        chk("t6_dlat",  dcyc_b - st,         43);
        chk("t6_addr",  {30'b0, addr_b},     32'd3);
        chk("t6_ferr",  {31'b0, ferr_b},     32'd0);
        chk("t6_busy",  {31'b0, busy_b},     32'd0);
        chk("t6_aidle", {31'b0, done_a},     32'd0);
        sel = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
